// File: rtl/vga_scan_engine.sv
// VGA sync/valid timing and scaled frame-buffer address generator, stepped by a pixel-enable strobe.
// Define VGA_SCROLL_EN to enable frame-latched scroll offsets with modular image wrap.
module vga_scan_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  parameter int SCALE_SHIFT = 1,
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int ADDR_W      = 17,
  parameter int MEM_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [9:0]        h_cnt,
  output logic [9:0]        v_cnt,
  output logic              valid,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH   = MEM_LAT + 1;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]        hc, vc;
  logic              primed;
  logic              h_wrap, v_wrap, f_wrap;
  logic              act, hs_a, vs_a;
  logic [9:0]        hx, vy, ix, iy;
  logic [ADDR_W-1:0] addr_c;

  logic [9:0] h_p   [DEPTH];
  logic [9:0] v_p   [DEPTH];
  logic       vld_p [DEPTH];
  logic       hs_p  [DEPTH];
  logic       vs_p  [DEPTH];
  logic       sof_p [MEM_LAT];

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);
  assign f_wrap = h_wrap && v_wrap;

  // Scan counters; primed marks that a full frame has elapsed since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc     <= '0;
      vc     <= '0;
      primed <= 1'b0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hc <= '0;
        vc <= v_wrap ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
      if (f_wrap) primed <= 1'b1;
    end
  end

  // ---- stage 0: timing decode and image coordinates from hc/vc ----
  assign act  = (hc < H_ACT) && (vc < V_ACT);
  assign hs_a = (hc >= HS_BEG) && (hc < HS_END);
  assign vs_a = (vc >= VS_BEG) && (vc < VS_END);

`ifdef VGA_SCROLL_EN
  localparam logic [9:0] IMG_W_L = 10'(IMG_W);
  localparam logic [9:0] IMG_H_L = 10'(IMG_H);

  logic [9:0] sx, sy;

  // Offsets only change at the frame wrap so a frame is never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (pix_en && f_wrap) begin
      sx <= (scroll_x >= IMG_W_L) ? '0 : scroll_x;
      sy <= (scroll_y >= IMG_H_L) ? '0 : scroll_y;
    end
  end

  function automatic logic [9:0] wrap_add(input logic [9:0] a, input logic [9:0] b,
                                          input logic [9:0] lim);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, lim}) s = s - {1'b0, lim};
    return s[9:0];
  endfunction
`else
  logic unused_scroll;
  assign unused_scroll = ^{scroll_x, scroll_y, 32'(IMG_H)};
`endif

  always_comb begin
    hx = hc >> SCALE_SHIFT;
    vy = vc >> SCALE_SHIFT;
`ifdef VGA_SCROLL_EN
    ix = wrap_add(hx, sx, IMG_W_L);
    iy = wrap_add(vy, sy, IMG_H_L);
`else
    ix = hx;
    iy = vy;
`endif
    addr_c = ADDR_W'(32'(iy) * 32'(IMG_W) + 32'(ix));
  end

  // ---- stage 0 -> MEM_LAT: address issue and timing delay line ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_addr  <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        h_p[i]   <= '0;
        v_p[i]   <= '0;
        vld_p[i] <= 1'b0;
        hs_p[i]  <= 1'b0;
        vs_p[i]  <= 1'b0;
      end
      for (int i = 0; i < MEM_LAT; i++) sof_p[i] <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        pixel_addr <= act ? addr_c : '0;
        h_p[0]     <= hc;
        v_p[0]     <= vc;
        vld_p[0]   <= act;
        hs_p[0]    <= hs_a;
        vs_p[0]    <= vs_a;
        sof_p[0]   <= primed && (hc == '0) && (vc == '0);
        for (int i = 1; i < DEPTH; i++) begin
          h_p[i]   <= h_p[i-1];
          v_p[i]   <= v_p[i-1];
          vld_p[i] <= vld_p[i-1];
          hs_p[i]  <= hs_p[i-1];
          vs_p[i]  <= vs_p[i-1];
        end
        for (int i = 1; i < MEM_LAT; i++) sof_p[i] <= sof_p[i-1];
        // The tag for the stage now entering the output slot.
        frame_start <= sof_p[MEM_LAT-1];
      end
    end
  end

  // ---- output stage: MEM_LAT ticks behind pixel_addr ----
  assign h_cnt = h_p[MEM_LAT];
  assign v_cnt = v_p[MEM_LAT];
  assign valid = vld_p[MEM_LAT];
  assign hsync = (SYNC_POL != 0) ? hs_p[MEM_LAT] : ~hs_p[MEM_LAT];
  assign vsync = (SYNC_POL != 0) ? vs_p[MEM_LAT] : ~vs_p[MEM_LAT];

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: small raster, two instances (MEM_LAT=1 active-low, MEM_LAT=3 active-high).
module tb_vga_scan_engine;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int IW = 8, IH = 6, SH = 1, AW = 17;
  localparam int OW = AW + 24;
  localparam logic [OW-1:0] RST_A = OW'(6);
  localparam logic [OW-1:0] RST_B = '0;

  logic clk = 1'b0;
  logic rst, pix_en;
  logic [9:0] scroll_x, scroll_y;
  logic [AW-1:0] addr_a, addr_b;
  logic [9:0] h_a, v_a, h_b, v_b;
  logic valid_a, hsync_a, vsync_a, fs_a;
  logic valid_b, hsync_b, vsync_b, fs_b;
  logic [OW-1:0] obs_a, obs_b;

  int checks = 0, failures = 0;
  int k, sx_m, sy_m, addr_m;
  logic en_last;

  always #5 clk = ~clk;

  vga_scan_engine #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0), .SCALE_SHIFT(SH), .IMG_W(IW), .IMG_H(IH),
    .ADDR_W(AW), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .pixel_addr(addr_a), .h_cnt(h_a), .v_cnt(v_a), .valid(valid_a), .hsync(hsync_a),
    .vsync(vsync_a), .frame_start(fs_a));

  vga_scan_engine #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1), .SCALE_SHIFT(SH), .IMG_W(IW), .IMG_H(IH),
    .ADDR_W(AW), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .pixel_addr(addr_b), .h_cnt(h_b), .v_cnt(v_b), .valid(valid_b), .hsync(hsync_b),
    .vsync(vsync_b), .frame_start(fs_b));

  assign obs_a = {addr_a, h_a, v_a, valid_a, hsync_a, vsync_a, fs_a};
  assign obs_b = {addr_b, h_b, v_b, valid_b, hsync_b, vsync_b, fs_b};

  // Reference: k = pix_en ticks since reset; tick k issues the address of raster index k-1
  // and presents the timing of raster index k-1-lat.
  task automatic model_reset();
    k = 0; sx_m = 0; sy_m = 0; addr_m = 0; en_last = 1'b0;
  endtask

  task automatic model_tick();
    int h, v, ix, iy;
    h = k % HT;
    v = (k / HT) % VT;
    if (h < HA && v < VA) begin
      ix = (h >> SH) + sx_m; if (ix >= IW) ix -= IW;
      iy = (v >> SH) + sy_m; if (iy >= IH) iy -= IH;
      addr_m = iy * IW + ix;
    end else begin
      addr_m = 0;
    end
    k++;
`ifdef VGA_SCROLL_EN
    if (k % FR == 0) begin
      sx_m = (scroll_x < IW) ? int'(scroll_x) : 0;
      sy_m = (scroll_y < IH) ? int'(scroll_y) : 0;
    end
`endif
  endtask

  function automatic logic [OW-1:0] exp_out(input int lat, input int pol);
    int j, h, v;
    logic val, hs, vs, fs;
    j = k - 1 - lat;
    h = 0; v = 0; val = 0; hs = 0; vs = 0; fs = 0;
    if (j >= 0) begin
      h = j % HT;
      v = (j / HT) % VT;
      val = (h < HA) && (v < VA);
      hs = (h >= HA + HF) && (h < HA + HF + HS);
      vs = (v >= VA + VF) && (v < VA + VF + VS);
      fs = en_last && (j > 0) && (j % FR == 0);
    end
    if (pol == 0) begin hs = ~hs; vs = ~vs; end
    return {AW'(addr_m), 10'(h), 10'(v), val, hs, vs, fs};
  endfunction

  task automatic drive(input logic en);
    @(negedge clk);
    pix_en = en;
    @(posedge clk);
    if (en) model_tick();
    en_last = en;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_en = 1'b0; scroll_x = '0; scroll_y = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      pix_en = (i == 1);
      @(posedge clk); #1;
      checks++;
      if (obs_a !== RST_A) begin failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, RST_A); end
      checks++;
      if (obs_b !== RST_B) begin failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, RST_B); end
    end
    @(negedge clk);
    pix_en = 1'b0; rst = 1'b0;
  endtask

  task automatic test_frames();
    int ticks = 0, vcount = 0, hcount = 0;
    logic en;
    while (ticks < 2 * FR + 100) begin
      if ($urandom_range(0, 60) == 0) begin
        scroll_x = 10'($urandom_range(0, IW + 4));
        scroll_y = 10'($urandom_range(0, IH + 4));
      end
      en = ($urandom_range(0, 2) == 0);
      drive(en);
      if (en) begin
        ticks++;
        if (ticks > 10 && ticks <= 10 + FR) begin
          vcount += int'(valid_a);
          hcount += int'(!hsync_a);
        end
      end
      checks++;
      if (obs_a !== exp_out(1, 0)) begin
        failures++; $display("FAIL frames_a k=%0d got=%h exp=%h", k, obs_a, exp_out(1, 0));
      end
      checks++;
      if (obs_b !== exp_out(3, 1)) begin
        failures++; $display("FAIL frames_b k=%0d got=%h exp=%h", k, obs_b, exp_out(3, 1));
      end
    end
    checks++;
    if (vcount != HA * VA) begin failures++; $display("FAIL valid_count got=%0d exp=%0d", vcount, HA * VA); end
    checks++;
    if (hcount != HS * VT) begin failures++; $display("FAIL hsync_count got=%0d exp=%0d", hcount, HS * VT); end
  endtask

  task automatic test_scroll(input int sxv, input int syv, input int e00, input int e60, input int e04);
    int f, idx;
    logic en;
    scroll_x = 10'(sxv); scroll_y = 10'(syv);
    f = k / FR + 1;
    idx = k - 1;
    while (idx < f * FR + 4 * HT + 1) begin
      en = ($urandom_range(0, 1) == 0);
      drive(en);
      idx = k - 1;
      checks++;
      if (obs_a !== exp_out(1, 0)) begin
        failures++; $display("FAIL scroll_a k=%0d got=%h exp=%h", k, obs_a, exp_out(1, 0));
      end
      checks++;
      if (obs_b !== exp_out(3, 1)) begin
        failures++; $display("FAIL scroll_b k=%0d got=%h exp=%h", k, obs_b, exp_out(3, 1));
      end
      if (en && idx / FR == f) begin
        if (idx % FR == 0) begin
          checks++;
          if (addr_a !== AW'(e00)) begin failures++; $display("FAIL scroll_00 got=%0d exp=%0d", addr_a, e00); end
        end
        if (idx % FR == 6) begin
          checks++;
          if (addr_a !== AW'(e60)) begin failures++; $display("FAIL scroll_60 got=%0d exp=%0d", addr_a, e60); end
        end
        if (idx % FR == 4 * HT) begin
          checks++;
          if (addr_a !== AW'(e04)) begin failures++; $display("FAIL scroll_04 got=%0d exp=%0d", addr_a, e04); end
        end
      end
    end
  endtask

  task automatic test_stall();
    while (k % HT != 7) drive(1'b1);
    for (int i = 0; i < 1000 + 60; i++) begin
      drive(i >= 1000);
      checks++;
      if (obs_a !== exp_out(1, 0)) begin
        failures++; $display("FAIL stall_a k=%0d got=%h exp=%h", k, obs_a, exp_out(1, 0));
      end
      checks++;
      if (obs_b !== exp_out(3, 1)) begin
        failures++; $display("FAIL stall_b k=%0d got=%h exp=%h", k, obs_b, exp_out(3, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int ka = 0, kb = 0;
    logic en;
    while (k % FR != 5 * HT + 9) drive(1'b1);
    @(negedge clk);
    pix_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs_a !== RST_A) begin failures++; $display("FAIL midreset_now_a got=%h exp=%h", obs_a, RST_A); end
    checks++;
    if (obs_b !== RST_B) begin failures++; $display("FAIL midreset_now_b got=%h exp=%h", obs_b, RST_B); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== RST_A) begin failures++; $display("FAIL midreset_hold_a got=%h exp=%h", obs_a, RST_A); end
    end
    @(negedge clk);
    pix_en = 1'b0; rst = 1'b0;
    for (int n = 0; n < 4 * FR && (ka == 0 || kb == 0); n++) begin
      en = ($urandom_range(0, 1) == 0);
      drive(en);
      checks++;
      if (obs_a !== exp_out(1, 0)) begin
        failures++; $display("FAIL after_reset_a k=%0d got=%h exp=%h", k, obs_a, exp_out(1, 0));
      end
      checks++;
      if (obs_b !== exp_out(3, 1)) begin
        failures++; $display("FAIL after_reset_b k=%0d got=%h exp=%h", k, obs_b, exp_out(3, 1));
      end
      if (fs_a === 1'b1 && ka == 0) ka = k;
      if (fs_b === 1'b1 && kb == 0) kb = k;
    end
    checks++;
    if (ka != FR + 2) begin failures++; $display("FAIL first_fs_a got=%0d exp=%0d", ka, FR + 2); end
    checks++;
    if (kb != FR + 4) begin failures++; $display("FAIL first_fs_b got=%0d exp=%0d", kb, FR + 4); end
  endtask

  initial begin
    test_reset();
    test_frames();
`ifdef VGA_SCROLL_EN
    test_scroll(5, 4, 4 * IW + 5, 4 * IW + 0, 0 * IW + 5);
    test_scroll(IW + 2, 1, 1 * IW, 1 * IW + 3, 3 * IW);
`else
    test_scroll(5, 4, 0, 3, 2 * IW);
    test_scroll(IW + 2, 1, 0, 3, 2 * IW);
`endif
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
